// File: rtl/gals_dispatch_unit.sv
// Timestep sequencer: broadcasts input spikes to the PE array, then
// handshakes each end-of-timestep with the GALS collector over AER req/ack.
module gals_dispatch_unit #(
    parameter  int IN_ADDR_W        = 8,
    parameter  int NUM_TIMESTEPS    = 16,
    parameter  int WATCHDOG_TIMEOUT = 10000,
    localparam int TS_W             = $clog2(NUM_TIMESTEPS) + 1,
    localparam int WD_W             = $clog2(WATCHDOG_TIMEOUT + 1)
) (
    input  logic                 local_clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_evt_valid,
    input  logic [IN_ADDR_W-1:0] i_evt_addr,
    input  logic                 i_evt_null,
    input  logic                 i_evt_last,
    output logic                 o_evt_ready,
    output logic                 o_spike_valid,
    output logic [IN_ADDR_W-1:0] o_spike_addr,
    input  logic                 i_spike_ready,
    output logic                 o_aer_req,
    input  logic                 i_aer_ack,
    output logic [TS_W-1:0]      o_timestep,
    output logic [15:0]          o_spike_cnt,
    output logic                 o_done,
    output logic                 o_error,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BCAST,
        S_SYNC,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [TS_W-1:0] LAST_TS = TS_W'(NUM_TIMESTEPS - 1);
    localparam logic [WD_W-1:0] WD_LIM  = WD_W'(WATCHDOG_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [IN_ADDR_W-1:0] addr_q, addr_d;
    logic                 null_q, null_d;
    logic                 last_q, last_d;
    logic                 spike_valid_q, spike_valid_d;
    logic                 aer_req_q, aer_req_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        null_d  = null_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    ts_d    = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                    addr_d  = '0;
                    null_d  = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_evt_valid) begin
                    addr_d = i_evt_addr;
                    null_d = i_evt_null;
                    last_d = i_evt_last;
                    if (!i_evt_null) begin
                        state_d = S_BCAST;
                    end else if (i_evt_last) begin
                        state_d = S_SYNC;
                    end
                end
            end
            S_BCAST: begin
                if (i_spike_ready) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = last_q ? S_SYNC : S_FETCH;
                end
            end
            S_SYNC: begin
                // ack is checked first so an ack on the timeout edge wins
                if (i_aer_ack) begin
                    wd_d  = '0;
                    cnt_d = '0;
                    if (ts_q == LAST_TS) begin
                        state_d = S_DONE;
                    end else begin
                        ts_d    = ts_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_q >= WD_LIM) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        spike_valid_d = (state_d == S_BCAST);
        aer_req_d     = (state_d == S_SYNC);
        done_d        = (state_d == S_DONE);
        error_d       = error_q | (state_d == S_ERROR);
    end

    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ts_q          <= '0;
            cnt_q         <= '0;
            wd_q          <= '0;
            addr_q        <= '0;
            null_q        <= 1'b0;
            last_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            aer_req_q     <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ts_q          <= ts_d;
            cnt_q         <= cnt_d;
            wd_q          <= wd_d;
            addr_q        <= addr_d;
            null_q        <= null_d;
            last_q        <= last_d;
            spike_valid_q <= spike_valid_d;
            aer_req_q     <= aer_req_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign o_evt_ready   = (state_q == S_FETCH);
    assign o_busy        = (state_q != S_IDLE);
    assign o_spike_valid = spike_valid_q;
    assign o_spike_addr  = addr_q;
    assign o_aer_req     = aer_req_q;
    assign o_timestep    = ts_q;
    assign o_spike_cnt   = cnt_q;
    assign o_done        = done_q;
    assign o_error       = error_q;

endmodule

// File: tb/tb_gals_dispatch_unit.sv
// Directed bench for gals_dispatch_unit with two timesteps and a short
// watchdog so every sequencing corner is reachable in a few cycles.
module tb_gals_dispatch_unit;

    localparam int AW  = 8;
    localparam int NTS = 2;
    localparam int WDT = 8;
    localparam int TSW = $clog2(NTS) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic           i_evt_valid = 1'b0;
    logic [AW-1:0]  i_evt_addr = '0;
    logic           i_evt_null = 1'b0;
    logic           i_evt_last = 1'b0;
    logic           o_evt_ready;
    logic           o_spike_valid;
    logic [AW-1:0]  o_spike_addr;
    logic           i_spike_ready = 1'b0;
    logic           o_aer_req;
    logic           i_aer_ack = 1'b0;
    logic [TSW-1:0] o_timestep;
    logic [15:0]    o_spike_cnt;
    logic           o_done;
    logic           o_error;
    logic           o_busy;

    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] xfer_q[$];

    gals_dispatch_unit #(
        .IN_ADDR_W(AW),
        .NUM_TIMESTEPS(NTS),
        .WATCHDOG_TIMEOUT(WDT)
    ) dut (
        .local_clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_evt_valid(i_evt_valid),
        .i_evt_addr(i_evt_addr),
        .i_evt_null(i_evt_null),
        .i_evt_last(i_evt_last),
        .o_evt_ready(o_evt_ready),
        .o_spike_valid(o_spike_valid),
        .o_spike_addr(o_spike_addr),
        .i_spike_ready(i_spike_ready),
        .o_aer_req(o_aer_req),
        .i_aer_ack(i_aer_ack),
        .o_timestep(o_timestep),
        .o_spike_cnt(o_spike_cnt),
        .o_done(o_done),
        .o_error(o_error),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_spike_valid && i_spike_ready) begin
            xfer_cnt++;
            xfer_q.push_back(o_spike_addr);
        end
        if (o_done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic n, input logic l);
        i_evt_valid = 1'b1;
        i_evt_addr  = a;
        i_evt_null  = n;
        i_evt_last  = l;
        tick;
        i_evt_valid = 1'b0;
        i_evt_null  = 1'b0;
        i_evt_last  = 1'b0;
    endtask

    task automatic start_run;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
    endtask

    task automatic ack_now;
        i_aer_ack = 1'b1;
        tick;
        i_aer_ack = 1'b0;
    endtask

    task automatic apply_reset;
        i_start = 1'b0;
        i_evt_valid = 1'b0;
        i_aer_ack = 1'b0;
        i_spike_ready = 1'b0;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        apply_reset;
        tests++;
        if ({o_evt_ready, o_spike_valid, o_aer_req, o_done, o_error, o_busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {o_evt_ready, o_spike_valid, o_aer_req, o_done, o_error, o_busy});
        end
        tests++;
        if (o_timestep !== TSW'(0) || o_spike_cnt !== 16'd0 || o_spike_addr !== 8'd0) begin
            fails++;
            $display("FAIL reset_counters: got ts=%0d cnt=%0d addr=%0h expected 0 0 0",
                     o_timestep, o_spike_cnt, o_spike_addr);
        end
    endtask

    task automatic test_basic;
        int x0 = xfer_cnt;
        int q0 = xfer_q.size();
        int d0 = done_cnt;
        i_spike_ready = 1'b1;
        start_run;
        tests++;
        if (o_busy !== 1'b1 || o_evt_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_start: got busy=%b ready=%b expected 1 1", o_busy, o_evt_ready);
        end
        for (int ts = 0; ts < NTS; ts++) begin
            send(8'd3, 1'b0, 1'b0);
            tests++;
            if (o_spike_valid !== 1'b1 || o_spike_addr !== 8'd3) begin
                fails++;
                $display("FAIL basic_bcast3: got v=%b a=%0h expected 1 3", o_spike_valid, o_spike_addr);
            end
            tick;
            send(8'd7, 1'b0, 1'b1);
            tick;
            tests++;
            if (o_aer_req !== 1'b1 || o_spike_cnt !== 16'd2) begin
                fails++;
                $display("FAIL basic_req: got req=%b cnt=%0d expected 1 2", o_aer_req, o_spike_cnt);
            end
            repeat (4) tick;
            ack_now;
            tests++;
            if (o_aer_req !== 1'b0) begin
                fails++;
                $display("FAIL basic_req_drop: got %b expected 0", o_aer_req);
            end
            if (ts < NTS - 1) begin
                tests++;
                if (o_timestep !== TSW'(ts + 1) || o_evt_ready !== 1'b1 || o_spike_cnt !== 16'd0) begin
                    fails++;
                    $display("FAIL basic_advance: got ts=%0d rdy=%b cnt=%0d expected %0d 1 0",
                             o_timestep, o_evt_ready, o_spike_cnt, ts + 1);
                end
            end
        end
        tests++;
        if (o_done !== 1'b1 || o_timestep !== TSW'(1)) begin
            fails++;
            $display("FAIL basic_done: got done=%b ts=%0d expected 1 1", o_done, o_timestep);
        end
        tick;
        tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_timestep !== TSW'(1)) begin
            fails++;
            $display("FAIL basic_idle: got done=%b busy=%b ts=%0d expected 0 0 1",
                     o_done, o_busy, o_timestep);
        end
        tests++;
        if (xfer_cnt - x0 != 4 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL basic_counts: got xfers=%0d dones=%0d expected 4 1",
                     xfer_cnt - x0, done_cnt - d0);
        end
        tests++;
        if (xfer_q.size() != q0 + 4 || xfer_q[q0] !== 8'd3 || xfer_q[q0+1] !== 8'd7 ||
            xfer_q[q0+2] !== 8'd3 || xfer_q[q0+3] !== 8'd7) begin
            fails++;
            $display("FAIL basic_order: got %0d entries expected 3 7 3 7", xfer_q.size() - q0);
        end
    endtask

    task automatic test_empty;
        int x0 = xfer_cnt;
        i_spike_ready = 1'b1;
        start_run;
        send(8'h21, 1'b1, 1'b0);
        tests++;
        if (o_evt_ready !== 1'b1 || o_spike_valid !== 1'b0 || o_aer_req !== 1'b0) begin
            fails++;
            $display("FAIL empty_drop: got rdy=%b v=%b req=%b expected 1 0 0",
                     o_evt_ready, o_spike_valid, o_aer_req);
        end
        send(8'h22, 1'b1, 1'b1);
        tests++;
        if (o_aer_req !== 1'b1 || o_spike_valid !== 1'b0 || o_spike_cnt !== 16'd0) begin
            fails++;
            $display("FAIL empty_req: got req=%b v=%b cnt=%0d expected 1 0 0",
                     o_aer_req, o_spike_valid, o_spike_cnt);
        end
        ack_now;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        tests++;
        if (o_done !== 1'b1 || xfer_cnt != x0) begin
            fails++;
            $display("FAIL empty_done: got done=%b xfers=%0d expected 1 0", o_done, xfer_cnt - x0);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int x0 = xfer_cnt;
        logic bad = 1'b0;
        i_spike_ready = 1'b0;
        start_run;
        send(8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (o_spike_valid !== 1'b1 || o_spike_addr !== 8'h55 || o_evt_ready !== 1'b0)
                bad = 1'b1;
            tick;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: got unstable=%b expected 0", bad);
        end
        i_spike_ready = 1'b1;
        tick;
        tests++;
        if (o_aer_req !== 1'b1 || xfer_cnt - x0 != 1 || o_spike_cnt !== 16'd1) begin
            fails++;
            $display("FAIL bp_xfer: got req=%b xfers=%0d cnt=%0d expected 1 1 1",
                     o_aer_req, xfer_cnt - x0, o_spike_cnt);
        end
        ack_now;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        tick;
    endtask

    task automatic test_spurious;
        i_spike_ready = 1'b0;
        start_run;
        i_aer_ack = 1'b1;
        i_start = 1'b1;
        tick;
        i_aer_ack = 1'b0;
        i_start = 1'b0;
        tests++;
        if (o_timestep !== TSW'(0) || o_evt_ready !== 1'b1 || o_aer_req !== 1'b0) begin
            fails++;
            $display("FAIL spur_fetch: got ts=%0d rdy=%b req=%b expected 0 1 0",
                     o_timestep, o_evt_ready, o_aer_req);
        end
        send(8'h09, 1'b0, 1'b0);
        i_aer_ack = 1'b1;
        i_start = 1'b1;
        tick;
        i_aer_ack = 1'b0;
        i_start = 1'b0;
        tests++;
        if (o_spike_valid !== 1'b1 || o_timestep !== TSW'(0) || o_spike_cnt !== 16'd0) begin
            fails++;
            $display("FAIL spur_bcast: got v=%b ts=%0d cnt=%0d expected 1 0 0",
                     o_spike_valid, o_timestep, o_spike_cnt);
        end
        i_spike_ready = 1'b1;
        tick;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        tests++;
        if (o_done !== 1'b1) begin
            fails++;
            $display("FAIL spur_done: got %b expected 1", o_done);
        end
        tick;
    endtask

    task automatic test_watchdog;
        apply_reset;
        start_run;
        send(8'h00, 1'b1, 1'b1);
        repeat (WDT - 1) tick;
        tests++;
        if (o_error !== 1'b0 || o_aer_req !== 1'b1) begin
            fails++;
            $display("FAIL wd_early: got err=%b req=%b expected 0 1", o_error, o_aer_req);
        end
        tick;
        tests++;
        if (o_error !== 1'b1 || o_aer_req !== 1'b0 || o_evt_ready !== 1'b0 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL wd_trip: got err=%b req=%b rdy=%b busy=%b expected 1 0 0 1",
                     o_error, o_aer_req, o_evt_ready, o_busy);
        end
        ack_now;
        start_run;
        repeat (3) tick;
        tests++;
        if (o_error !== 1'b1 || o_busy !== 1'b1 || o_spike_valid !== 1'b0) begin
            fails++;
            $display("FAIL wd_sticky: got err=%b busy=%b v=%b expected 1 1 0",
                     o_error, o_busy, o_spike_valid);
        end
        apply_reset;
        tests++;
        if (o_error !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL wd_clear: got err=%b busy=%b expected 0 0", o_error, o_busy);
        end
    endtask

    task automatic test_ack_on_timeout;
        start_run;
        send(8'h00, 1'b1, 1'b1);
        repeat (WDT - 1) tick;
        ack_now;
        tests++;
        if (o_error !== 1'b0 || o_timestep !== TSW'(1) || o_evt_ready !== 1'b1) begin
            fails++;
            $display("FAIL wd_ack_edge: got err=%b ts=%0d rdy=%b expected 0 1 1",
                     o_error, o_timestep, o_evt_ready);
        end
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        tick;
    endtask

    task automatic test_reset_mid;
        i_spike_ready = 1'b1;
        start_run;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        send(8'h00, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        tests++;
        if (o_aer_req !== 1'b0 || o_busy !== 1'b0 || o_timestep !== TSW'(0)) begin
            fails++;
            $display("FAIL rst_sync: got req=%b busy=%b ts=%0d expected 0 0 0",
                     o_aer_req, o_busy, o_timestep);
        end
        tick;
        rst_n = 1'b1;
        tick;
        i_spike_ready = 1'b0;
        start_run;
        tests++;
        if (o_timestep !== TSW'(0) || o_evt_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_restart: got ts=%0d rdy=%b expected 0 1", o_timestep, o_evt_ready);
        end
        send(8'h11, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (o_spike_valid !== 1'b0 || o_spike_addr !== 8'h00 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_bcast: got v=%b a=%0h busy=%b expected 0 0 0",
                     o_spike_valid, o_spike_addr, o_busy);
        end
        tick;
        rst_n = 1'b1;
        tick;
        i_spike_ready = 1'b1;
        start_run;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        send(8'h00, 1'b1, 1'b1);
        ack_now;
        tests++;
        if (o_done !== 1'b1 || o_error !== 1'b0) begin
            fails++;
            $display("FAIL rst_clean_run: got done=%b err=%b expected 1 0", o_done, o_error);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_empty;
        test_backpressure;
        test_spurious;
        test_watchdog;
        test_ack_on_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gals_dispatch_unit.md
# gals_dispatch_unit

Timestep sequencer that sits directly upstream of the GALS collector stage. It pulls input spike events from an event source and broadcasts each one to the PE array over a valid/ready channel. At each end-of-timestep marker it raises the global AER request toward the collector and holds it until the collector's one-cycle acknowledge, then advances to the next timestep. A watchdog flags a collector that never acknowledges.

## Interface
- IN_ADDR_W, 8: width of a spike (input neuron) address
- NUM_TIMESTEPS, 16: timesteps per run, ≥1
- WATCHDOG_TIMEOUT, 10000: max cycles `o_aer_req` may stay high without an ack
- local_clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- i_start  in  1  one-cycle pulse; starts a run when idle, ignored otherwise
- i_evt_valid  in  1  event word available
- i_evt_addr  in  IN_ADDR_W  spike address
- i_evt_null  in  1  event carries no spike (marker only)
- i_evt_last  in  1  event closes the current timestep
- o_evt_ready  out  1  event accepted when valid&ready
- o_spike_valid  out  1  spike broadcast valid
- o_spike_addr  out  IN_ADDR_W  broadcast address, stable while valid
- i_spike_ready  in  1  AND of all PE readies
- o_aer_req  out  1  global timestep-complete request to collector
- i_aer_ack  in  1  one-cycle ack pulse from collector, same clock
- o_timestep  out  $clog2(NUM_TIMESTEPS)+1  current timestep index
- o_spike_cnt  out  16  spikes broadcast in current timestep, saturating
- o_done  out  1  one-cycle pulse after last timestep acked
- o_error  out  1  sticky watchdog error
- o_busy  out  1  state != S_IDLE

## Operation
- States: S_IDLE, S_FETCH, S_BCAST, S_SYNC, S_DONE, S_ERROR.
- All outputs registered except `o_evt_ready` (= state==S_FETCH) and `o_busy`.
- S_IDLE: on `i_start`: clear timestep, spike_cnt, watchdog, latched fields → S_FETCH.
- S_FETCH: `o_evt_ready`=1. On valid:
  - latch addr/null/last;
  - !null → S_BCAST;
  - null&last → S_SYNC;
  - null&!last → stay S_FETCH (event dropped).
- S_BCAST: `o_spike_valid`=1, `o_spike_addr`=latched addr. On `i_spike_ready`: spike_cnt+1 (saturate at 16'hFFFF), then last → S_SYNC, else → S_FETCH. No timeout; backpressure is unbounded.
- S_SYNC: `o_aer_req`=1, watchdog+1 per cycle.
  - ack has priority over timeout when both occur in the same cycle.
  - On `i_aer_ack`: req drops at the same edge, watchdog cleared, spike_cnt cleared. If timestep==NUM_TIMESTEPS-1 → S_DONE, else timestep+1 → S_FETCH.
  - Watchdog ≥ WATCHDOG_TIMEOUT without ack → S_ERROR.
- S_DONE: `o_done`=1 for one cycle; timestep holds NUM_TIMESTEPS-1 → S_IDLE.
- S_ERROR: `o_error`=1, `o_aer_req`=0, `o_evt_ready`=0, `o_spike_valid`=0; exits only by reset.
- `i_aer_ack` outside S_SYNC is ignored. `i_start` while busy is ignored.

## Timing
- Reset values: all outputs 0; state S_IDLE; all counters 0.
- Reset mid-run aborts immediately. `o_aer_req` and `o_spike_valid` fall asynchronously with `rst_n`.
- `i_start` at edge N → `o_busy`=1 and `o_evt_ready`=1 in cycle N+1.
- Spike event accepted at edge N → `o_spike_valid`=1 in cycle N+1. With `i_spike_ready` held high, one spike per 2 cycles.
- Last event accepted at edge N (null) or last spike handshake at edge N → `o_aer_req`=1 in cycle N+1.
- `o_aer_req` is low in the cycle after the ack edge. The collector, back in idle, must not see req high, so no double-trigger.
- Ack at edge N for timestep k<NUM_TIMESTEPS-1 → `o_timestep`=k+1 and `o_evt_ready`=1 in cycle N+1.
- Watchdog: req asserted in cycle N with no ack → S_ERROR entered at edge N+WATCHDOG_TIMEOUT.
- Ack arriving exactly on the timeout edge wins.

## Test plan
- Basic run (NUM_TIMESTEPS=2): per timestep send addrs 3, 7 (last on 7), ready=1, ack 5 cycles after req.
  - Required: spikes 3, 7 each broadcast once; `o_spike_cnt`=2 at req.
  - Required: req deasserts the cycle after each ack; `o_done` pulses once; `o_timestep` ends at 1.
- Empty timestep: single null&last event.
  - Required: no `o_spike_valid`; `o_aer_req` the cycle after acceptance.
  - Required: null&!last events are consumed with no broadcast.
- Backpressure: `i_spike_ready` low for 20 cycles during addr 0x55.
  - Required: valid and addr held stable throughout; exactly one transfer; `o_evt_ready` stays 0 meanwhile.
- Watchdog (WATCHDOG_TIMEOUT=8): never ack.
  - Required: `o_error`=1 exactly 8 cycles after req rose; req drops; state sticky until `rst_n`.
  - Variant: ack on the timeout edge → no error, run proceeds.
- Spurious inputs: ack pulses in S_FETCH/S_BCAST and `i_start` while busy.
  - Required: no effect on timestep or state.
- Reset mid-S_SYNC and mid-S_BCAST.
  - Required: all outputs 0 immediately; a fresh `i_start` runs cleanly from timestep 0.
